// File: rtl/baccarat_pkg.sv
// Shared types, card codes and the card value helper for the baccarat sequencer.
package baccarat_pkg;

    typedef enum logic [2:0] {
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        DECIDE_P,
        DECIDE_D,
        FINISH
    } state_t;

    localparam logic [3:0] CARD_BLANK = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_TWO   = 4'd2;
    localparam logic [3:0] CARD_THREE = 4'd3;
    localparam logic [3:0] CARD_FOUR  = 4'd4;
    localparam logic [3:0] CARD_FIVE  = 4'd5;
    localparam logic [3:0] CARD_SIX   = 4'd6;
    localparam logic [3:0] CARD_SEVEN = 4'd7;
    localparam logic [3:0] CARD_EIGHT = 4'd8;
    localparam logic [3:0] CARD_NINE  = 4'd9;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    // Scores at or above this on the first two cards end the round at once.
    localparam logic [3:0] NATURAL_MIN = 4'd8;

    // Baccarat value of a card: pips count face value, tens and faces count zero.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        case (code)
            CARD_ACE, CARD_TWO, CARD_THREE, CARD_FOUR, CARD_FIVE,
            CARD_SIX, CARD_SEVEN, CARD_EIGHT, CARD_NINE: return code;
            CARD_BLANK, CARD_TEN, CARD_JACK, CARD_QUEEN, CARD_KING: return '0;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/baccarat_draw_rule.sv
// Dealer third-card rule: decides whether the dealer draws given the dealer
// score and, if the player drew, the player's third card.
module baccarat_draw_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    input  logic       player_drew,
    output logic       dealer_draws
);

    logic [3:0] v;

    // Tableau lookup on dealer score versus the player's third-card value.
    always_comb begin
        v            = card_value(pcard3);
        dealer_draws = 1'b0;
        if (!player_drew) begin
            dealer_draws = (dscore <= 4'd5);
        end else begin
            case (dscore)
                4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
                4'd3:             dealer_draws = (v != 4'd8);
                4'd4:             dealer_draws = (v >= 4'd2) && (v <= 4'd7);
                4'd5:             dealer_draws = (v >= 4'd4) && (v <= 4'd7);
                4'd6:             dealer_draws = (v >= 4'd6) && (v <= 4'd7);
                default:          dealer_draws = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// Baccarat round sequencer: issues card-register load strobes for each deal
// step, applies the third-card rules and lights the winner.
// Build option AUTO_DEAL_EN: steps come from an internal AUTO_PERIOD timer and
// the step port is ignored.
module baccarat_sequencer
    import baccarat_pkg::*;
#(
    parameter int unsigned AUTO_PERIOD = 50000000
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    // The step timer is 26 bits wide; reject periods it cannot count.
    if (AUTO_PERIOD < 1 || AUTO_PERIOD > 67108864) begin : g_bad_period
        $error("AUTO_PERIOD out of range");
    end

    state_t state;
    logic   go;
    logic   player_drew;
    logic   dealer_draws;

`ifdef AUTO_DEAL_EN
    localparam logic [25:0] AUTO_LAST = 26'(AUTO_PERIOD - 1);

    logic [25:0] auto_count;
    logic        auto_step;
    logic        unused_step;

    assign unused_step = step;

    // Free-running timer emitting a one-cycle step every AUTO_PERIOD cycles.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            auto_count <= '0;
            auto_step  <= 1'b0;
        end else if (auto_count == AUTO_LAST) begin
            auto_count <= '0;
            auto_step  <= 1'b1;
        end else begin
            auto_count <= auto_count + 26'd1;
            auto_step  <= 1'b0;
        end
    end

    assign go = auto_step;
`else
    logic step_q;

    // Previous step level; tracked through reset so a step held across
    // release does not count as a new request.
    always_ff @(posedge slow_clock) begin
        step_q <= step;
    end

    assign go = step & ~step_q;
`endif

    baccarat_draw_rule u_draw_rule (
        .dscore       (dscore),
        .pcard3       (pcard3),
        .player_drew  (player_drew),
        .dealer_draws (dealer_draws)
    );

    // Round FSM with registered strobes and result lights.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state       <= DEAL_P1;
            player_drew <= 1'b0;
            load_pcard1 <= 1'b0;
            load_pcard2 <= 1'b0;
            load_pcard3 <= 1'b0;
            load_dcard1 <= 1'b0;
            load_dcard2 <= 1'b0;
            load_dcard3 <= 1'b0;
            player_win  <= 1'b0;
            dealer_win  <= 1'b0;
            done        <= 1'b0;
        end else begin
            load_pcard1 <= 1'b0;
            load_pcard2 <= 1'b0;
            load_pcard3 <= 1'b0;
            load_dcard1 <= 1'b0;
            load_dcard2 <= 1'b0;
            load_dcard3 <= 1'b0;
            if (go) begin
                case (state)
                    DEAL_P1: begin
                        load_pcard1 <= 1'b1;
                        state       <= DEAL_D1;
                    end
                    DEAL_D1: begin
                        load_dcard1 <= 1'b1;
                        state       <= DEAL_P2;
                    end
                    DEAL_P2: begin
                        load_pcard2 <= 1'b1;
                        state       <= DEAL_D2;
                    end
                    DEAL_D2: begin
                        load_dcard2 <= 1'b1;
                        state       <= DECIDE_P;
                    end
                    DECIDE_P: begin
                        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) begin
                            state <= FINISH;
                        end else if (pscore <= 4'd5) begin
                            load_pcard3 <= 1'b1;
                            player_drew <= 1'b1;
                            state       <= DECIDE_D;
                        end else begin
                            player_drew <= 1'b0;
                            state       <= DECIDE_D;
                        end
                    end
                    DECIDE_D: begin
                        load_dcard3 <= dealer_draws;
                        state       <= FINISH;
                    end
                    FINISH: begin
                        if (!done) begin
                            player_win <= (pscore >= dscore);
                            dealer_win <= (dscore >= pscore);
                            done       <= 1'b1;
                        end
                    end
                    default: state <= DEAL_P1;
                endcase
            end
        end
    end

endmodule
